// File: rtl/clock_divider_multi_if.sv
// Divisor-write handshake between a configuring master and clock_divider_multi.
interface clock_divider_multi_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned DIV_W = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_chan, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_chan, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable tick/square-wave divider on BOARD_CLK.
// Optional phase-align strobe sync_in is compiled in when CLKDIV_SYNC_EN is defined.
module clock_divider_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned DEFAULT_DIV = 6000000,
  parameter int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                BOARD_CLK,
  input  logic                BOARD_RST_N,
  input  logic                en,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync_in,
`endif
  clock_divider_multi_if.slave cfg,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq
);

  logic [DIV_W-1:0]    r_cnt [CHANNELS];
  logic [DIV_W-1:0]    r_div [CHANNELS];
  logic [CHANNELS-1:0] r_tick;
  logic [CHANNELS-1:0] r_sq;
  logic                r_pend_valid;
  logic [CH_W-1:0]     r_pend_chan;
  logic [DIV_W-1:0]    r_pend_div;

  logic [DIV_W-1:0]    w_eff_m1 [CHANNELS];
  logic [CHANNELS-1:0] w_term;
  logic [CHANNELS-1:0] w_apply;
  logic                w_pend_ok;
  logic                w_cfg_fire;
  logic                w_pend_clear;
  logic                w_sync;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif

  always_comb begin
    w_term     = '0;
    w_apply    = '0;
    w_pend_ok  = r_pend_valid && (32'(r_pend_chan) < CHANNELS);
    w_cfg_fire = cfg.cfg_valid && !r_pend_valid;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      // A stored divisor of 0 behaves as 1, so terminal count is then 0.
      w_eff_m1[i] = (r_div[i] == '0) ? '0 : r_div[i] - DIV_W'(1);
      w_term[i]   = (r_cnt[i] == w_eff_m1[i]);
      w_apply[i]  = w_pend_ok && (r_pend_chan == CH_W'(i)) &&
                    (w_sync || !en || w_term[i]);
    end
    // Out-of-range channels never match, so the slot simply drains.
    w_pend_clear = r_pend_valid && (w_sync || !w_pend_ok || (|w_apply));
  end

  always_ff @(posedge BOARD_CLK or negedge BOARD_RST_N) begin
    if (!BOARD_RST_N) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
        r_div[i] <= DIV_W'(DEFAULT_DIV);
      end
      r_tick       <= '0;
      r_sq         <= '0;
      r_pend_valid <= 1'b0;
      r_pend_chan  <= '0;
      r_pend_div   <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (w_sync) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
          r_sq[i]   <= 1'b0;
        end else if (en) begin
          if (w_term[i]) begin
            r_cnt[i]  <= '0;
            r_tick[i] <= 1'b1;
            r_sq[i]   <= ~r_sq[i];
          end else begin
            r_cnt[i]  <= r_cnt[i] + DIV_W'(1);
            r_tick[i] <= 1'b0;
          end
        end else begin
          r_tick[i] <= 1'b0;
          if (w_apply[i]) r_cnt[i] <= '0;
        end
        if (w_apply[i]) r_div[i] <= r_pend_div;
      end

      if (w_pend_clear) begin
        r_pend_valid <= 1'b0;
      end else if (w_cfg_fire) begin
        r_pend_valid <= 1'b1;
        r_pend_chan  <= cfg.cfg_chan;
        r_pend_div   <= cfg.cfg_div;
      end
    end
  end

  assign tick          = r_tick;
  assign sq            = r_sq;
  assign cfg.cfg_ready = ~r_pend_valid;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomized bench for clock_divider_multi against a cycles-remaining reference model.
module tb_clock_divider_multi;

  localparam int unsigned CHN = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned DEF = 5;
  localparam int unsigned CW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           sync_i = 1'b0;
  logic [CHN-1:0] tick;
  logic [CHN-1:0] sq;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  clock_divider_multi_if #(.CH_W(CW), .DIV_W(DW)) cfg_if ();

  clock_divider_multi #(
    .CHANNELS(CHN), .DIV_W(DW), .DEFAULT_DIV(DEF), .CH_W(CW)
  ) dut (
    .BOARD_CLK  (clk),
    .BOARD_RST_N(rst_n),
    .en         (en),
`ifdef CLKDIV_SYNC_EN
    .sync_in    (sync_i),
`endif
    .cfg        (cfg_if),
    .tick       (tick),
    .sq         (sq)
  );

  always #5 clk = ~clk;

  // Reference: per channel, enabled edges remaining until the next tick.
  int          m_left [CHN];
  int          m_div  [CHN];
  logic [CHN-1:0] m_tick, m_sq;
  logic        m_pv;
  int          m_pc, m_pd;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CHN; i++) begin
      m_div[i]  = DEF;
      m_left[i] = DEF;
    end
    m_tick = '0;
    m_sq   = '0;
    m_pv   = 1'b0;
    m_pc   = 0;
    m_pd   = 0;
  endtask

  task automatic model_edge(input logic e, input logic v, input int ch, input int dv, input logic sy);
    logic accepted_now;
    logic consumed;
    accepted_now = v && !m_pv;
    consumed = 1'b0;
    if (m_pv && m_pc >= CHN) consumed = 1'b1;
    for (int i = 0; i < CHN; i++) begin
      logic mine;
      mine = m_pv && (m_pc == i);
      if (sy) begin
        if (mine) begin m_div[i] = m_pd; consumed = 1'b1; end
        m_tick[i] = 1'b0;
        m_sq[i]   = 1'b0;
        m_left[i] = eff(m_div[i]);
      end else if (e) begin
        if (m_left[i] == 1) begin
          m_tick[i] = 1'b1;
          m_sq[i]   = ~m_sq[i];
          if (mine) begin m_div[i] = m_pd; consumed = 1'b1; end
          m_left[i] = eff(m_div[i]);
        end else begin
          m_tick[i] = 1'b0;
          m_left[i] = m_left[i] - 1;
        end
      end else begin
        m_tick[i] = 1'b0;
        if (mine) begin
          m_div[i]  = m_pd;
          m_left[i] = eff(m_pd);
          consumed  = 1'b1;
        end
      end
    end
    if (m_pv && (sy || consumed)) m_pv = 1'b0;
    else if (accepted_now) begin
      m_pv = 1'b1;
      m_pc = ch;
      m_pd = dv;
    end
  endtask

  task automatic step(input logic e, input logic v, input int ch, input int dv, input logic sy);
    en               = e;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_chan  = CW'(ch);
    cfg_if.cfg_div   = DW'(dv);
`ifdef CLKDIV_SYNC_EN
    sync_i = sy;
`else
    sync_i = 1'b0;
`endif
    @(posedge clk);
    model_edge(e, v, ch, dv, sync_i);
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("sq", 32'(sq), 32'(m_sq));
    check("ready", 32'(cfg_if.cfg_ready), 32'(!m_pv));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sq", 32'(sq), 32'd0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_div   = '0;
    model_reset();

    // Free run: first tick on edge 5, then every 5, sq period 10.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step(1, 0, 0, 0, 0);
      if (c == 5)  check("first_tick", 32'(tick), 32'd3);
      if (c == 10) check("sq_back_low", 32'(sq), 32'd0);
    end

    // Pause for 7 cycles after 3 enabled: next tick 2 enabled edges after resume.
    do_reset();
    for (int c = 0; c < 3; c++) step(1, 0, 0, 0, 0);
    for (int c = 0; c < 7; c++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("resume_1", 32'(tick), 32'd0);
    step(1, 0, 0, 0, 0);
    check("resume_2", 32'(tick), 32'd3);

    // Retarget channel 1 to 3 at edge 2.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 3, 0);
    check("wr_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    for (int c = 3; c <= 14; c++) begin
      step(1, 0, 0, 0, 0);
      if (c == 5) check("wr_old_tick", 32'(tick), 32'd3);
      if (c == 8) check("wr_new_tick", 32'(tick), 32'd2);
    end

    // Divisor 0 on channel 0: tick every cycle once applied.
    step(1, 1, 0, 0, 0);
    for (int c = 0; c < 8; c++) step(1, 0, 0, 0, 0);

    // Out-of-range channel is accepted then dropped.
    step(1, 1, 3, 2, 0);
    check("bad_ch_ready0", 32'(cfg_if.cfg_ready), 32'd0);
    step(1, 0, 0, 0, 0);
    check("bad_ch_ready1", 32'(cfg_if.cfg_ready), 32'd1);
    for (int c = 0; c < 6; c++) step(1, 0, 0, 0, 0);

`ifdef CLKDIV_SYNC_EN
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 2, 0);
    for (int c = 3; c <= 6; c++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    check("sync_clear", 32'({tick, sq}), 32'd0);
    for (int c = 0; c < 8; c++) step(1, 0, 0, 0, 0);
`endif

    // Randomized traffic, including async reset mid-stream.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic e, v, sy;
      e  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 5) == 0);
      sy = ($urandom_range(0, 60) == 0);
      step(e, v, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), sy);
      if ($urandom_range(0, 400) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
